// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S link constants and sample type for the RX and TX ends
package i2s_pkg;

  // Bit-clock periods per channel slot and per stereo frame
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 2 * SLOT_W;

  // Equalizer sample as carried on the link
  typedef logic signed [23:0] sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - bit-clock divider producing bclk and a falling-edge strobe
module i2s_clkgen #(
  parameter int SCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap   = (div_cnt == DW'(SCLK_DIV - 1));
  // High in the cycle whose closing edge takes bclk from 1 to 0
  assign fall_o = wrap && bclk_o;

  // Half-period divider: toggle bclk every SCLK_DIV clocks
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      bclk_o  <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk_o  <= ~bclk_o;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter, mono sample duplicated on both slots; option I2S_TX_UNDERRUN_HOLD_EN
module i2s_tx #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int SCLK_DIV = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sample_valid_i,
  output logic                       sample_ready_o,
  output logic                       bclk_o,
  output logic                       lrclk_o,
  output logic                       sdata_o,
  output logic                       underrun_o
);
  import i2s_pkg::*;

  localparam int FRAME_N = 2 * SLOT_W;
  localparam int CW      = $clog2(FRAME_N);

  logic                       fall;
  logic [CW-1:0]              bit_cnt;
  logic [CW-1:0]              nxt_cnt;
  logic                       frame_start;
  logic                       slot_start;
  logic                       xfer;
  logic                       hold_full;
  logic signed [SAMPLE_W-1:0] hold;
  logic signed [SAMPLE_W-1:0] active;
  logic signed [SAMPLE_W-1:0] nxt_active;
  logic [SAMPLE_W-1:0]        shreg;

  i2s_clkgen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_clkgen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bclk_o (bclk_o),
    .fall_o (fall)
  );

  // Next bit position, frame/slot boundaries and the sample the next frame will carry
  always_comb begin
    nxt_cnt     = (bit_cnt == CW'(FRAME_N - 1)) ? '0 : bit_cnt + CW'(1);
    frame_start = fall && (bit_cnt == CW'(FRAME_N - 1));
    slot_start  = (nxt_cnt == '0) || (nxt_cnt == CW'(SLOT_W));
    xfer        = sample_valid_i && sample_ready_o;
    if (hold_full) begin
      nxt_active = hold;
    end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      // Starved: repeat the last sample rather than drop to silence
      nxt_active = active;
`else
      nxt_active = '0;
`endif
    end
  end

  // Bit counter, word select and serializer, all advanced on bclk falling edges
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= CW'(FRAME_N - 1);
      lrclk_o <= 1'b0;
      sdata_o <= 1'b0;
      shreg   <= '0;
    end else if (fall) begin
      bit_cnt <= nxt_cnt;
      lrclk_o <= (nxt_cnt >= CW'(SLOT_W));
      if (slot_start) begin
        // One-bclk I2S delay: slot position 0 is always a zero, MSB follows
        sdata_o <= 1'b0;
        shreg   <= frame_start ? nxt_active : active;
      end else begin
        // Zeros shift in behind the sample, so padding bits come out as 0
        sdata_o <= shreg[SAMPLE_W-1];
        shreg   <= {shreg[SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  // Holding register handshake and frame-start hand-over to the active sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold           <= '0;
      hold_full      <= 1'b0;
      sample_ready_o <= 1'b1;
      active         <= '0;
      underrun_o     <= 1'b0;
    end else begin
      underrun_o <= frame_start && !hold_full;
      if (frame_start) begin
        active <= nxt_active;
      end
      if (frame_start && hold_full) begin
        // Ready was low this cycle, so no new sample can collide with the hand-over
        hold_full      <= 1'b0;
        sample_ready_o <= 1'b1;
      end else if (xfer) begin
        hold           <= sample_i;
        hold_full      <= 1'b1;
        sample_ready_o <= 1'b0;
      end
    end
  end

endmodule
